// File: rtl/pe_request_arbiter.sv
// Round-robin arbiter sharing one processing element between NUM_REQ window sources.
// Issued requester IDs go into a tag FIFO so that PE results are routed back in order.
module pe_request_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int IN_DATA_WIDTH  = 216,
  parameter int OUT_DATA_WIDTH = 128,
  parameter int TAG_DEPTH      = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ*IN_DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ack,
  output logic [IN_DATA_WIDTH-1:0]           pe_i_data,
  output logic                               pe_i_valid,
  input  logic                               pe_ready,
  input  logic                               pe_ack,
  input  logic [OUT_DATA_WIDTH-1:0]          pe_o_data,
  input  logic                               pe_o_valid,
  output logic [OUT_DATA_WIDTH-1:0]          out_data,
  output logic [NUM_REQ-1:0]                 out_valid,
  output logic [$clog2(TAG_DEPTH):0]         inflight,
  output logic                               tag_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   tag_mem [TAG_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            can_arb;

  assign inflight  = count;
  assign push      = (state == ISSUE) && pe_ack;
  assign pop       = pe_o_valid && (count != '0);
  assign can_arb   = pe_ready && (count < CW'(TAG_DEPTH)) && (|req_valid);
  assign pe_i_data = req_data[int'(grant)*IN_DATA_WIDTH +: IN_DATA_WIDTH];

  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    int idx;
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (req_valid[idx]) pick = GW'(idx);
    end
  end

  always_comb begin
    req_ack = '0;
    if (push) req_ack[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      pe_i_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_data   <= '0;
      out_valid  <= '0;
      tag_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (can_arb) begin
            grant      <= pick;
            state      <= ISSUE;
            pe_i_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (pe_ack) begin
            state      <= IDLE;
            pe_i_valid <= 1'b0;
            rr_ptr     <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        out_data <= pe_o_data;
      end
      out_valid <= pop ? (NUM_REQ'(1) << tag_mem[rd_ptr]) : '0;

      if (pe_o_valid && (count == '0)) tag_err <= 1'b1;

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/pe_request_arbiter.md
# pe_request_arbiter

Round-robin arbiter and sequencer sharing one `pe_incha_single`-style processing element between `NUM_REQ` window sources (line-buffer/window generators). It grants one requester at a time onto the PE's `i_data`/`i_valid`/`pe_ready`/`pe_ack` handshake. It records the granted requester ID in a tag FIFO. When the PE's gathered `o_data`/`o_valid` result returns, it routes that result back to the originating requester.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `IN_DATA_WIDTH`, 216, width of one window word (8*IN_CHANNEL*KERNEL_PTS)
- `OUT_DATA_WIDTH`, 128, width of one PE result word (OUTPUT_DATA_WIDTH*OUT_CHANNEL)
- `TAG_DEPTH`, 4, tag FIFO depth (power of two, ≥2); maximum results in flight
- `clk`  input  1  clock; all logic on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `req_data`  input  NUM_REQ*IN_DATA_WIDTH  window words, requester r at bits [r*IN_DATA_WIDTH +: IN_DATA_WIDTH]
- `req_valid`  input  NUM_REQ  request per requester; data held stable until `req_ack`
- `req_ack`  output  NUM_REQ  one-cycle pulse, word accepted by PE
- `pe_i_data`  output  IN_DATA_WIDTH  to PE `i_data`
- `pe_i_valid`  output  1  to PE `i_valid`
- `pe_ready`  input  1  from PE, PE idle
- `pe_ack`  input  1  from PE, PE latched `i_data` this cycle
- `pe_o_data`  input  OUT_DATA_WIDTH  from PE `o_data`
- `pe_o_valid`  input  1  from PE `o_valid`
- `out_data`  output  OUT_DATA_WIDTH  routed result, shared by all requesters
- `out_valid`  output  NUM_REQ  one-hot result strobe
- `inflight`  output  $clog2(TAG_DEPTH)+1  tag FIFO occupancy
- `tag_err`  output  1  sticky: `pe_o_valid` arrived while the tag FIFO was empty

## Operation
- FSM with two states: IDLE and ISSUE.
- IDLE:
  - Arbitration is enabled when `pe_ready`=1, `inflight`<TAG_DEPTH and any `req_valid` is set.
  - When enabled, select the first set `req_valid` at or after `rr_ptr`, cyclically.
  - Register `grant`=that index; next state ISSUE.
- ISSUE:
  - `pe_i_valid`=1.
  - `pe_i_data`=`req_data[grant]`, muxed combinationally from the live input.
- On `pe_ack` in ISSUE:
  - `req_ack[grant]` pulses that same cycle.
  - Push `grant` into the tag FIFO.
  - `rr_ptr` becomes (`grant`+1) mod NUM_REQ.
  - Next state is IDLE.
- If `req_valid[grant]` drops in ISSUE: protocol violation. The block still completes the issue; no recovery is required.
- Result path:
  - On `pe_o_valid`, pop the tag.
  - Next cycle: `out_data`=registered `pe_o_data` and `out_valid`=1<<tag.
  - `out_data` holds its value between strobes.
- `pe_o_valid` with the FIFO empty: no pop, `out_valid` stays 0, `tag_err` sets to 1 until reset.
- Push and pop in the same cycle: `inflight` is unchanged and FIFO order is preserved.
- `rr_ptr` only advances on an accepted issue. Non-granted requesters keep waiting; no requester can starve beyond NUM_REQ-1 grants.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0, `grant`=0.
  - FIFO empty, `inflight`=0.
  - `pe_i_valid`=0, `req_ack`=0, `out_valid`=0, `out_data`=0, `tag_err`=0.
- Reset asserted mid-operation:
  - All of the above are cleared immediately (asynchronous).
  - Any pending tags are discarded.
- Issue latency: `req_valid` with arbitration enabled at cycle t → `pe_i_valid`=1 at t+1.
- `pe_ack` may arrive at t+1 or later; `pe_i_valid` and `pe_i_data` hold until it does.
- Back-to-back issues: after `pe_ack` at cycle a, IDLE at a+1; the earliest next `pe_i_valid` is a+2.
- Return latency: `pe_o_valid` at cycle c → `out_valid` at c+1, lasting exactly 1 cycle.
- `inflight` reflects pushes and pops registered on the cycle after the event.
- FIFO full (`inflight`=TAG_DEPTH): no new grant. A pop in cycle f allows a grant decision at f+1.
- `pe_ack` outside ISSUE is ignored.

## Test plan
- Single requester, NUM_REQ=2:
  - Stimulus: `req_valid`=2'b01, `pe_ready`=1, PE model acks 1 cycle after `pe_i_valid`, returns result 20 cycles later.
  - Response: `pe_i_data`=req_data[0], one `req_ack`=2'b01 pulse, `out_valid`=2'b01 with the matching `out_data`, `inflight` goes 0→1→0.
- Both requesters constantly valid for 6 issues:
  - Grants alternate 0,1,0,1,0,1.
  - Returns are strobed in the same order on `out_valid` bits.
- Four requesters valid {1,3}, `rr_ptr` at 2 → grant 3, then 1, then 3.
- TAG_DEPTH=4, PE never returns: exactly 4 `req_ack`s, `inflight`=4, then no `pe_i_valid`. One `pe_o_valid` → 5th issue starts 2 cycles later.
- Push/pop collide: `pe_ack` and `pe_o_valid` in the same cycle with `inflight`=2 → `inflight` stays 2 and the popped tag is the oldest.
- Spurious `pe_o_valid` after reset → `tag_err`=1 held, `out_valid` stays 0. Assert `rst_n`=0 mid-ISSUE → `pe_i_valid`=0 and `inflight`=0 immediately.
